// File: rtl/clkdiv_monitor.sv
// rtl/clkdiv_monitor.sv - divided-clock waveform monitor: edge pulses, run lengths, lock/fault health
// Samples div_in in the clk domain, measures high/low runs and tracks lock against expected lengths.
module clkdiv_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  input  logic             clear,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    ST_ACQUIRE,
    ST_LOCKED,
    ST_FAULT
  } state_e;

  localparam logic [CNT_W-1:0] RUN_MAX   = '1;
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_CNT - 1);

  logic             div_q;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             got_edge_q, have_low_q;
  logic             rise_q, fall_q;
  logic [CNT_W-1:0] high_len_q, low_len_q;
  logic             meas_valid_q, match_q;
  logic             period_match_d;
  state_e           state_q;
  logic [3:0]       mcnt_q;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             transition;
  logic             stuck;

  assign transition = (div_in != div_q);
  assign stuck      = (run_cnt_q == RUN_MAX) && !transition;

  always_comb begin
    if (transition) begin
      run_cnt_d = CNT_W'(1);
    end else if (run_cnt_q == RUN_MAX) begin
      run_cnt_d = run_cnt_q;
    end else begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
    // run_cnt_q is the high run ending at this falling edge
    period_match_d = (run_cnt_q == exp_high) && (low_len_q == exp_low) &&
                     (exp_high != '0) && (exp_low != '0);
    err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_q        <= 1'b0;
      run_cnt_q    <= '0;
      got_edge_q   <= 1'b0;
      have_low_q   <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      high_len_q   <= '0;
      low_len_q    <= '0;
      meas_valid_q <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      div_q <= div_in;
      // clear discards everything, including a transition on the same edge
      if (clear) begin
        run_cnt_q    <= '0;
        got_edge_q   <= 1'b0;
        have_low_q   <= 1'b0;
        rise_q       <= 1'b0;
        fall_q       <= 1'b0;
        high_len_q   <= '0;
        low_len_q    <= '0;
        meas_valid_q <= 1'b0;
        match_q      <= 1'b0;
      end else begin
        run_cnt_q    <= run_cnt_d;
        rise_q       <= transition & div_in;
        fall_q       <= transition & ~div_in;
        meas_valid_q <= 1'b0;
        if (transition) begin
          if (!got_edge_q) begin
            got_edge_q <= 1'b1;
          end else if (div_in) begin
            low_len_q  <= run_cnt_q;
            have_low_q <= 1'b1;
          end else begin
            high_len_q <= run_cnt_q;
            if (have_low_q) begin
              meas_valid_q <= 1'b1;
              match_q      <= period_match_d;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      state_q   <= ST_ACQUIRE;
      mcnt_q    <= 4'd0;
      err_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        ST_ACQUIRE: begin
          if (stuck) begin
            mcnt_q <= 4'd0;
          end else if (meas_valid_q) begin
            if (!match_q) begin
              mcnt_q <= 4'd0;
            end else if (mcnt_q == LOCK_LAST) begin
              state_q <= ST_LOCKED;
              mcnt_q  <= 4'd0;
            end else begin
              mcnt_q <= mcnt_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (meas_valid_q && !match_q) begin
            state_q   <= ST_FAULT;
            err_cnt_q <= err_cnt_d;
          end else if (stuck) begin
            state_q <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (meas_valid_q && !match_q) begin
            err_cnt_q <= err_cnt_d;
          end
        end
        default: state_q <= ST_ACQUIRE;
      endcase
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign high_len   = high_len_q;
  assign low_len    = low_len_q;
  assign meas_valid = meas_valid_q;
  assign locked     = (state_q == ST_LOCKED);
  assign err        = (state_q == ST_FAULT);
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clkdiv_monitor.sv
// tb/tb_clkdiv_monitor.sv - self-checking bench for clkdiv_monitor
// Event-stamped reference model checked every cycle, plus scenario table and directed corner sequences.
module tb_clkdiv_monitor;

  localparam int MAXR = 255;
  localparam int LOCKN = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       div_in = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] exp_high = 8'd0;
  logic [7:0] exp_low = 8'd0;
  logic       rise_pulse, fall_pulse, meas_valid, locked, err;
  logic [7:0] high_len, low_len, err_cnt;

  int total = 0;
  int bad = 0;
  bit mdl_on = 1'b0;

  always #5 clk = ~clk;

  clkdiv_monitor #(.CNT_W(8), .LOCK_CNT(LOCKN)) dut (
    .clk(clk), .resetn(resetn), .div_in(div_in), .exp_high(exp_high), .exp_low(exp_low),
    .clear(clear), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .high_len(high_len),
    .low_len(low_len), .meas_valid(meas_valid), .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: runs measured from cycle stamps of the last transition.
  int  t = 0, t_last = 0;
  bit  m_p, m_got, m_hl, m_rise, m_fall, m_mv, m_match;
  int  m_hi, m_lo, m_state, m_streak, m_err;

  task automatic m_clear_all();
    m_got = 0; m_hl = 0; m_rise = 0; m_fall = 0; m_mv = 0; m_match = 0;
    m_hi = 0; m_lo = 0; m_state = 0; m_streak = 0; m_err = 0;
    t_last = t + 1;
  endtask

  always @(posedge clk) begin
    bit trans, stuck;
    int len;
    t++;
    if (!resetn) begin
      m_clear_all();
      m_p = 0;
    end else begin
      trans = (div_in != m_p);
      stuck = !trans && ((t - t_last) >= MAXR);
      if (clear) begin
        m_clear_all();
      end else begin
        // health reacts to the measurement published on the previous edge
        if (m_state == 0) begin
          if (stuck) m_streak = 0;
          else if (m_mv) begin
            if (m_match) begin
              m_streak++;
              if (m_streak == LOCKN) begin m_state = 1; m_streak = 0; end
            end else m_streak = 0;
          end
        end else if (m_state == 1) begin
          if (m_mv && !m_match) begin m_state = 2; if (m_err < 255) m_err++; end
          else if (stuck) m_state = 2;
        end else begin
          if (m_mv && !m_match && m_err < 255) m_err++;
        end
        m_rise = trans && div_in;
        m_fall = trans && !div_in;
        m_mv = 0;
        if (trans) begin
          len = (t - t_last > MAXR) ? MAXR : t - t_last;
          if (!m_got) m_got = 1;
          else if (div_in) begin m_lo = len; m_hl = 1; end
          else begin
            m_hi = len;
            if (m_hl) begin
              m_mv = 1;
              m_match = (len == int'(exp_high)) && (m_lo == int'(exp_low)) &&
                        (exp_high != 0) && (exp_low != 0);
            end
          end
          t_last = t;
        end
      end
      m_p = div_in;
    end
  end

  always @(negedge clk) begin
    if (mdl_on)
      chk("model", {3'b0, rise_pulse, fall_pulse, high_len, low_len, meas_valid, locked, err, err_cnt},
          {3'b0, m_rise, m_fall, 8'(m_hi), 8'(m_lo), m_mv, m_state == 1, m_state == 2, 8'(m_err)});
  end

  task automatic tick(input logic d);
    div_in = d;
    @(negedge clk);
  endtask

  task automatic period(input int h, input int l);
    repeat (h) tick(1'b1);
    repeat (l) tick(1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; clear = 1'b0; div_in = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    int         h, l;
    logic [7:0] eh, el;
    int         n;
    logic       lk, er;
    int         hi, lo;
  } vec_t;

  vec_t vt[5];
  bit   lvl;

  initial begin
    vt[0] = '{3, 3, 8'd3, 8'd3, 5, 1'b1, 1'b0, 3, 3};
    vt[1] = '{3, 3, 8'd3, 8'd3, 4, 1'b0, 1'b0, 3, 3};
    vt[2] = '{1, 1, 8'd1, 8'd1, 6, 1'b1, 1'b0, 1, 1};
    vt[3] = '{2, 2, 8'd0, 8'd2, 8, 1'b0, 1'b0, 2, 2};
    vt[4] = '{2, 3, 8'd2, 8'd3, 5, 1'b1, 1'b0, 2, 3};

    do_reset();
    mdl_on = 1'b1;
    chk("reset_outputs", {rise_pulse, fall_pulse, high_len, low_len, meas_valid, locked, err, err_cnt}, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      exp_high = vt[i].eh; exp_low = vt[i].el;
      repeat (vt[i].n) period(vt[i].h, vt[i].l);
      chk($sformatf("vec%0d_locked", i), locked, vt[i].lk);
      chk($sformatf("vec%0d_err", i), err, vt[i].er);
      chk($sformatf("vec%0d_err_cnt", i), err_cnt, 0);
      chk($sformatf("vec%0d_high_len", i), high_len, vt[i].hi);
      chk($sformatf("vec%0d_low_len", i), low_len, vt[i].lo);
    end

    // div6: first measurement at the second falling edge
    do_reset();
    exp_high = 8'd3; exp_low = 8'd3;
    period(3, 3);
    chk("div6_no_meas_yet", meas_valid, 0);
    repeat (3) tick(1'b1);
    tick(1'b0);
    chk("div6_first_meas", {meas_valid, high_len, low_len}, {1'b1, 8'd3, 8'd3});

    // div2 edge pulses
    do_reset();
    exp_high = 8'd1; exp_low = 8'd1;
    tick(1'b1);
    chk("div2_rise", {rise_pulse, fall_pulse}, 2'b10);
    tick(1'b0);
    chk("div2_fall", {rise_pulse, fall_pulse}, 2'b01);

    // div4 lock, one long high run, sticky fault, clear, relock
    do_reset();
    exp_high = 8'd2; exp_low = 8'd2;
    repeat (5) period(2, 2);
    chk("div4_locked", locked, 1);
    repeat (3) tick(1'b1);
    tick(1'b0);
    chk("bad_meas", {meas_valid, high_len}, {1'b1, 8'd3});
    chk("bad_still_locked", locked, 1);
    tick(1'b0);
    chk("fault_state", {locked, err, err_cnt}, {1'b0, 1'b1, 8'd1});
    repeat (3) period(2, 2);
    chk("fault_sticky", {locked, err, err_cnt}, {1'b0, 1'b1, 8'd1});
    clear = 1'b1;
    tick(1'b0);
    clear = 1'b0;
    chk("clear_outputs", {rise_pulse, fall_pulse, high_len, low_len, meas_valid, locked, err, err_cnt}, 0);
    repeat (5) period(2, 2);
    chk("relock", {locked, err}, 2'b10);

    // stuck low while locked
    repeat (2) tick(1'b1);
    tick(1'b0);
    for (int k = 2; k <= 300; k++) begin
      tick(1'b0);
      if (k == 255) chk("stuck_not_yet", err, 0);
      if (k == 256) chk("stuck_fault", err, 1);
    end
    chk("stuck_err_cnt", err_cnt, 0);
    tick(1'b1);
    chk("stuck_low_len", low_len, 255);

    // acquire: 3 match, 1 mismatch, then 4 match
    do_reset();
    exp_high = 8'd2; exp_low = 8'd2;
    repeat (4) period(2, 2);
    period(3, 2);
    repeat (3) period(2, 2);
    chk("acq_restart_not_locked", locked, 0);
    period(2, 2);
    chk("acq_restart_locked", locked, 1);

    // reset mid-period while locked
    tick(1'b1);
    resetn = 1'b0;
    tick(1'b1);
    resetn = 1'b1;
    chk("midreset_outputs", {rise_pulse, fall_pulse, high_len, low_len, meas_valid, locked, err, err_cnt}, 0);
    tick(1'b1);
    chk("post_reset_first_edge", {rise_pulse, low_len}, {1'b1, 8'd0});
    tick(1'b1);
    tick(1'b0);
    chk("post_reset_high_cap", {meas_valid, high_len}, {1'b0, 8'd2});

    // clear coincident with a rising transition
    tick(1'b0);
    clear = 1'b1;
    tick(1'b1);
    clear = 1'b0;
    tick(1'b1);
    tick(1'b0);
    chk("clear_edge_discarded", {meas_valid, high_len, low_len}, 0);
    tick(1'b0);
    tick(1'b1);
    chk("clear_next_low_cap", low_len, 2);

    // err_cnt saturation
    do_reset();
    exp_high = 8'd2; exp_low = 8'd2;
    repeat (5) period(2, 2);
    repeat (260) period(1, 1);
    chk("err_cnt_sat", {err, err_cnt}, {1'b1, 8'd255});

    // random runs biased toward the expected lengths
    do_reset();
    exp_high = 8'd2; exp_low = 8'd3;
    lvl = 1'b0;
    for (int r = 0; r < 700; r++) begin
      int len;
      if ($urandom_range(0, 29) == 0) begin
        exp_high = 8'($urandom_range(1, 3));
        exp_low  = 8'($urandom_range(1, 3));
      end
      lvl = !lvl;
      if ($urandom_range(0, 3) != 0) len = lvl ? int'(exp_high) : int'(exp_low);
      else len = $urandom_range(1, 5);
      for (int c = 0; c < len; c++) begin
        clear = (c == 0) && ($urandom_range(0, 39) == 0);
        tick(lvl);
      end
      clear = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_monitor.md
# clkdiv_monitor

Measures the waveform of one divided-clock output (e.g. the /2, /4 or /6 output of the even clock divider) sampled in the `clk` domain. It reports edge pulses and measured high/low run lengths, and checks those lengths against programmed expectations. A lock/fault state machine gives the divider's consumer a single health indication. It sits directly downstream of the divider, in the same `clk` domain, with no synchronisers.

## Interface
- `CNT_W`, default 8: width of the run-length counter and of the length fields.
- `LOCK_CNT`, default 4: number of consecutive matching periods required to lock (1..15).
- `clk`  in  1: clock.
- `resetn`  in  1: reset; synchronous, active-low.
- `div_in`  in  1: divided waveform under test, synchronous to `clk`.
- `exp_high`  in  CNT_W: expected high run length in cycles; 0 never matches.
- `exp_low`  in  CNT_W: expected low run length in cycles; 0 never matches.
- `clear`  in  1: synchronous soft clear.
- `rise_pulse`  out  1: one-cycle pulse per rising edge of `div_in`.
- `fall_pulse`  out  1: one-cycle pulse per falling edge of `div_in`.
- `high_len`  out  CNT_W: last complete high run length.
- `low_len`  out  CNT_W: last complete low run length.
- `meas_valid`  out  1: one-cycle pulse when a full low+high period has been measured.
- `locked`  out  1: state is LOCKED.
- `err`  out  1: state is FAULT.
- `err_cnt`  out  8: saturating count of mismatching periods seen in LOCKED or FAULT.

## Operation
- `div_q` holds the previous sample of `div_in`.
- A transition is `div_in != div_q`:
  - rising when `div_in` = 1, falling when `div_in` = 0.
- `run_cnt` (CNT_W):
  - on a transition, loads 1;
  - otherwise increments, saturating at 2^CNT_W-1.
- `stuck` = `run_cnt` at saturation and no transition.
- Flags `got_edge`, `have_low`:
  - First transition after reset/clear sets `got_edge` only. The partial run is discarded; no capture.
  - Later rising transition: `low_len` <= `run_cnt`, `have_low` <= 1.
  - Later falling transition: `high_len` <= `run_cnt`. If `have_low` = 1, then `meas_valid` <= 1 and `match` <= (`high_len` value == `exp_high` && `low_len` == `exp_low` && both expectations nonzero).
- `rise_pulse`/`fall_pulse` are registered from the transition detect and are independent of `got_edge`.
- FSM states and transitions:
  - ACQUIRE, on `meas_valid`:
    - match: `mcnt`++; reaching LOCK_CNT moves to LOCKED and zeroes `mcnt`.
    - mismatch: `mcnt` <= 0.
    - `stuck`: `mcnt` <= 0.
  - LOCKED:
    - `meas_valid` with mismatch: go to FAULT, `err_cnt`++.
    - `stuck`: go to FAULT, no `err_cnt` change.
  - FAULT: sticky until `clear` or reset. Each mismatching `meas_valid` still increments `err_cnt`.
- `err_cnt` saturates at 255.
- Changing `exp_*` while LOCKED produces a mismatch and therefore FAULT; software must clear after reprogramming.
- `clear` has the same effect as reset on every register except `div_q`, which keeps tracking.
  - `clear` coincident with a transition: `clear` wins. The transition counts as the first edge only on the next one, i.e. it is discarded. `run_cnt` <= 0.
- Reset values: all outputs 0; `div_q` 0; `run_cnt` 0; state ACQUIRE; `mcnt` 0; all flags 0.

## Timing
- Transition sampled at edge k: `rise_pulse`/`fall_pulse`, `high_len`/`low_len`, `meas_valid` and `match` are all visible after edge k, for one cycle where pulsed.
- State, `locked`, `err` and `err_cnt` update at edge k+1, one cycle after `meas_valid`.
- `stuck` in LOCKED: FAULT is visible one cycle after `run_cnt` reaches saturation.
- Minimum supported run length is 1 (div2: a transition every cycle). Captured lengths are exactly the sample counts.
- `div_in` held 1 after reset counts as a rising transition at the first edge (`div_q` = 0). It only sets `got_edge`.

## Test plan
- div6 waveform (3 high/3 low), `exp_high`=`exp_low`=3, LOCK_CNT=4 -> first `meas_valid` at the 2nd falling edge with `high_len`=`low_len`=3; `locked` rises one cycle after the 4th `meas_valid` (5th falling edge); `err`=0, `err_cnt`=0.
- div2 waveform, `exp_*`=1 -> `rise_pulse`/`fall_pulse` alternate every cycle; `high_len`=`low_len`=1; lock after 4 periods.
- Locked on div4 (2/2), then inject one high run of 3 cycles -> `meas_valid` with `high_len`=3; FAULT next cycle (`locked`=0, `err`=1, `err_cnt`=1); further good periods keep FAULT and `err_cnt`=1; `clear` -> ACQUIRE, all outputs 0, relock after 4 good periods.
- Locked, CNT_W=8, hold `div_in`=0 for 300 cycles -> FAULT one cycle after `run_cnt` reaches 255; `err_cnt` unchanged; next `low_len` captured = 255.
- In ACQUIRE, 3 matching periods then 1 mismatch then 4 matching -> `locked` only after the final 4 (counter restarted); `exp_high`=0 -> never locks.
- `resetn` low mid-period while LOCKED -> next cycle all outputs 0, state ACQUIRE; first post-reset transition produces no capture; assert `clear` on the same edge as a rising transition -> no `low_len` capture on the following falling edge.
